mmio_responder: RTL and testbench

- Memory-side responder for the multicycle MIPS core. It serves the core's address/write-enable/write-data strobes.
- Decodes each word address to one of four targets: an internal data RAM, an LED output register, a debounced switch input, or a free-running timer.
- Returns registered read data with fixed one-cycle latency, which matches the core's address cycle followed by its memory-read cycle.
- Sits between the core datapath (address mux output, B register, Mem_Write) and the board pins.

---
 rtl/mmio_responder.sv | 198 +++++++++++++++++++
 tb/tb_mmio_responder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_responder.sv
// mmio_responder: word-addressed memory/IO responder for a multicycle MIPS core.
// It decodes the core's address into four targets: a data RAM, an LED register,
// debounced switches, and a free-running timer. It also holds a sticky error
// status bit. Read data is registered and always appears one cycle after the
// address is applied.
module mmio_responder #(
  parameter int RAM_DEPTH  = 64,
  parameter int DEB_CYCLES = 16,
  parameter int SW_W       = 8,
  parameter int LED_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  input  logic              mem_write,
  output logic [31:0]       rdata,
  input  logic [SW_W-1:0]   sw_in,
  output logic [LED_W-1:0]  led_out,
  output logic              bus_err
);
  localparam int AW = $clog2(RAM_DEPTH);
  localparam int CW = $clog2(DEB_CYCLES);

  // Word addresses (byte address >> 2)
  localparam logic [29:0] RAM_BASE  = 30'h0400_4000;  // 0x1001_0000
  localparam logic [29:0] ADDR_LED  = 30'h0400_7FC0;  // 0x1001_FF00
  localparam logic [29:0] ADDR_SW   = 30'h0400_7FC1;  // 0x1001_FF04
  localparam logic [29:0] ADDR_TMR  = 30'h0400_7FC2;  // 0x1001_FF08
  localparam logic [29:0] ADDR_STAT = 30'h0400_7FC3;  // 0x1001_FF0C

  typedef enum logic [2:0] {T_NONE, T_RAM, T_LED, T_SW, T_TMR, T_STAT} tgt_e;
  typedef enum logic {DB_IDLE, DB_COUNT} db_state_e;

  logic [29:0]      word_addr;
  logic             unused_byte_sel;
  logic [AW-1:0]    ram_idx;
  tgt_e             tgt;
  logic             ram_we;
  logic [31:0]      ram_q [RAM_DEPTH];

  logic [31:0]      rdata_q, rdata_d;
  logic [LED_W-1:0] led_q, led_d;
  logic [31:0]      tmr_q, tmr_d;
  logic             err_q, err_d;
  logic [SW_W-1:0]  sync1_q, sync2_q;
  db_state_e        db_state_q, db_state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [SW_W-1:0]  cand_q, cand_d;
  logic [SW_W-1:0]  stable_q, stable_d;

  // The core only does word accesses, so the byte lane bits carry no meaning.
  assign word_addr       = addr[31:2];
  assign unused_byte_sel = ^addr[1:0];
  assign ram_idx         = word_addr[AW-1:0];

  assign rdata   = rdata_q;
  assign led_out = led_q;
  assign bus_err = err_q;

  // Decode the word address into one target. RAM is aligned to its own size.
  always_comb begin
    tgt = T_NONE;
    if (word_addr[29:AW] == RAM_BASE[29:AW]) begin
      tgt = T_RAM;
    end else begin
      case (word_addr)
        ADDR_LED:  tgt = T_LED;
        ADDR_SW:   tgt = T_SW;
        ADDR_TMR:  tgt = T_TMR;
        ADDR_STAT: tgt = T_STAT;
        default:   tgt = T_NONE;
      endcase
    end
  end

  // Read mux. It samples pre-write state, so a write to the address being read
  // shows the old value.
  always_comb begin
    case (tgt)
      T_RAM:   rdata_d = ram_q[ram_idx];
      T_LED:   rdata_d = 32'(led_q);
      T_SW:    rdata_d = 32'(stable_q);
      T_TMR:   rdata_d = tmr_q;
      T_STAT:  rdata_d = {31'b0, err_q};
      default: rdata_d = '0;
    endcase
  end

  // Write decode. A timer load overrides the increment. Error sources and the
  // STATUS clear use different addresses, so set-wins needs no extra logic.
  always_comb begin
    led_d  = led_q;
    tmr_d  = tmr_q + 32'd1;
    err_d  = err_q;
    ram_we = mem_write && (tgt == T_RAM);
    if (mem_write) begin
      case (tgt)
        T_LED:  led_d = wdata[LED_W-1:0];
        T_TMR:  tmr_d = wdata;
        T_STAT: if (wdata[0]) err_d = 1'b0;
        T_SW:   err_d = 1'b1;
        T_NONE: err_d = 1'b1;
        default: ;
      endcase
    end
  end

  // Data RAM has no reset. A RAM write made during reset still lands.
  always_ff @(posedge clk) begin
    if (ram_we) ram_q[ram_idx] <= wdata;
  end

  // Bus-side registers and the switch synchronizer
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
      led_q   <= '0;
      tmr_q   <= '0;
      err_q   <= 1'b0;
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      rdata_q <= rdata_d;
      led_q   <= led_d;
      tmr_q   <= tmr_d;
      err_q   <= err_d;
      sync1_q <= sw_in;
      sync2_q <= sync1_q;
    end
  end

  // Debounce state register
  always_ff @(posedge clk) begin
    if (reset) begin
      db_state_q <= DB_IDLE;
      cnt_q      <= '0;
      cand_q     <= '0;
      stable_q   <= '0;
    end else begin
      db_state_q <= db_state_d;
      cnt_q      <= cnt_d;
      cand_q     <= cand_d;
      stable_q   <= stable_d;
    end
  end

  // Debounce next state: leave IDLE on any change, and go back once the
  // change is accepted or has bounced back to the stable value.
  always_comb begin
    db_state_d = db_state_q;
    case (db_state_q)
      DB_IDLE:  if (sync2_q != stable_q) db_state_d = DB_COUNT;
      DB_COUNT: begin
        if (sync2_q != cand_q) begin
          if (sync2_q == stable_q) db_state_d = DB_IDLE;
        end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
          db_state_d = DB_IDLE;
        end
      end
      default:  db_state_d = DB_IDLE;
    endcase
  end

  // Debounce datapath: the candidate value, its stability count, and the
  // accepted value
  always_comb begin
    cnt_d    = cnt_q;
    cand_d   = cand_q;
    stable_d = stable_q;
    case (db_state_q)
      DB_IDLE: begin
        cnt_d = '0;
        if (sync2_q != stable_q) begin
          cand_d = sync2_q;
          cnt_d  = CW'(1);
        end
      end
      DB_COUNT: begin
        if (sync2_q != cand_q) begin
          if (sync2_q == stable_q) begin
            cnt_d = '0;
          end else begin
            cand_d = sync2_q;
            cnt_d  = CW'(1);
          end
        end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
          stable_d = cand_q;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: cnt_d = '0;
    endcase
  end

endmodule

// File: tb/tb_mmio_responder.sv
// Testbench for mmio_responder. A reference model updates on each clock edge
// and queues the expected {rdata, led_out, bus_err}. A monitor pops one entry
// per cycle and compares it with the DUT outputs.
module tb_mmio_responder;
  localparam int RAM_DEPTH  = 64;
  localparam int DEB_CYCLES = 16;
  localparam int SW_W       = 8;
  localparam int LED_W      = 8;
  localparam int W          = 1 + 32 + LED_W + 1;  // {known, rdata, led, err}

  localparam logic [31:0] A_RAM  = 32'h1001_0000;
  localparam logic [31:0] A_LED  = 32'h1001_FF00;
  localparam logic [31:0] A_SW   = 32'h1001_FF04;
  localparam logic [31:0] A_TMR  = 32'h1001_FF08;
  localparam logic [31:0] A_STAT = 32'h1001_FF0C;

  localparam int K_NONE = 0, K_RAM = 1, K_LED = 2, K_SW = 3, K_TMR = 4, K_STAT = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic              mem_write;
  logic [31:0]       rdata;
  logic [SW_W-1:0]   sw_in;
  logic [LED_W-1:0]  led_out;
  logic              bus_err;

  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];

  mmio_responder #(
    .RAM_DEPTH(RAM_DEPTH), .DEB_CYCLES(DEB_CYCLES), .SW_W(SW_W), .LED_W(LED_W)
  ) dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .mem_write(mem_write),
    .rdata(rdata), .sw_in(sw_in), .led_out(led_out), .bus_err(bus_err)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [31:0]      m_ram [int];
  logic [LED_W-1:0] m_led;
  logic             m_err;
  logic [31:0]      m_tbase;
  longint           m_tcyc;
  longint           m_cyc = 0;
  logic [SW_W-1:0]  m_s1, m_s2, m_stable, m_run_val;
  int               m_run_len;

  function automatic int kind_of(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w >= A_RAM && w < A_RAM + 32'(4 * RAM_DEPTH)) return K_RAM;
    if (w == A_LED)  return K_LED;
    if (w == A_SW)   return K_SW;
    if (w == A_TMR)  return K_TMR;
    if (w == A_STAT) return K_STAT;
    return K_NONE;
  endfunction

  always @(posedge clk) begin
    int          k;
    int          idx;
    logic        known;
    logic [31:0] exp_rd;
    logic [31:0] cur_t;
    k      = kind_of(addr);
    idx    = int'((addr - A_RAM) >> 2);
    cur_t  = m_tbase + 32'(m_cyc - m_tcyc);
    known  = 1'b1;
    exp_rd = 32'h0;
    if (!reset) begin
      case (k)
        K_RAM:  if (m_ram.exists(idx)) exp_rd = m_ram[idx]; else known = 1'b0;
        K_LED:  exp_rd = 32'(m_led);
        K_SW:   exp_rd = 32'(m_stable);
        K_TMR:  exp_rd = cur_t;
        K_STAT: exp_rd = {31'b0, m_err};
        default: exp_rd = 32'h0;
      endcase
    end
    m_cyc++;
    if (mem_write && k == K_RAM) m_ram[idx] = wdata;
    if (reset) begin
      m_led = '0; m_err = 1'b0; m_tbase = 32'h0; m_tcyc = m_cyc;
      m_s1 = '0; m_s2 = '0; m_stable = '0; m_run_val = '0; m_run_len = 0;
    end else begin
      // A switch value is accepted once the synchronized value has stayed at a
      // new level for DEB_CYCLES consecutive samples.
      if (m_s2 == m_run_val) m_run_len++;
      else begin m_run_val = m_s2; m_run_len = 1; end
      if (m_s2 != m_stable && m_run_len == DEB_CYCLES) m_stable = m_s2;
      m_s2 = m_s1;
      m_s1 = sw_in;
      if (mem_write) begin
        case (k)
          K_LED:  m_led = wdata[LED_W-1:0];
          K_TMR:  begin m_tbase = wdata; m_tcyc = m_cyc; end
          K_STAT: if (wdata[0]) m_err = 1'b0;
          K_SW, K_NONE: m_err = 1'b1;
          default: ;
        endcase
      end
    end
    exp_q.push_back({known, exp_rd, m_led, m_err});
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [W-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e[W-1]) begin
          n_checks++;
          if (rdata === e[W-2 -: 32]) n_pass++;
          else $display("FAIL rdata t=%0t addr=%h got=%h exp=%h", $time, addr, rdata, e[W-2 -: 32]);
        end
        n_checks++;
        if (led_out === e[LED_W:1]) n_pass++;
        else $display("FAIL led_out t=%0t got=%h exp=%h", $time, led_out, e[LED_W:1]);
        n_checks++;
        if (bus_err === e[0]) n_pass++;
        else $display("FAIL bus_err t=%0t got=%b exp=%b", $time, bus_err, e[0]);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic [31:0] a, input logic [31:0] d, input logic we);
    @(negedge clk);
    reset = r; addr = a; wdata = d; mem_write = we;
  endtask

  task automatic rd(input logic [31:0] a, input int n);
    for (int i = 0; i < n; i++) step(1'b0, a, 32'h0, 1'b0);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 9))
      0, 1, 2: a = A_RAM + 32'(4 * $urandom_range(0, RAM_DEPTH - 1)) + 32'($urandom_range(0, 3));
      3: a = A_LED;
      4: a = A_SW;
      5: a = A_TMR;
      6: a = A_STAT;
      7: a = A_RAM + 32'(4 * RAM_DEPTH);
      8: a = A_RAM - 32'd4;
      default: a = $urandom();
    endcase
    return a;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; addr = 32'h0; wdata = 32'h0; mem_write = 1'b0; sw_in = '0;
    // Reset: an LED write is dropped, a RAM write still completes
    step(1'b1, A_LED, 32'hFF, 1'b1);
    step(1'b1, A_RAM + 32'd20, 32'h5555_AAAA, 1'b1);
    step(1'b1, 32'h0, 32'h0, 1'b0);
    rd(A_RAM + 32'd20, 2);
    rd(A_LED, 1);

    // Initialize the whole RAM
    for (int i = 0; i < RAM_DEPTH; i++) step(1'b0, A_RAM + 32'(4 * i), $urandom(), 1'b1);

    // RAM write/read, neighbour unchanged
    step(1'b0, A_RAM + 32'd8, 32'hDEAD_BEEF, 1'b1);
    rd(A_RAM + 32'd8, 2);
    rd(A_RAM + 32'd12, 2);

    // LED: only the low bits are stored
    step(1'b0, A_LED, 32'h0000_01A5, 1'b1);
    rd(A_LED, 2);

    // Timer load near wrap, continuous reads
    step(1'b0, A_TMR, 32'hFFFF_FFFE, 1'b1);
    rd(A_TMR, 5);

    // Errors: store to SW, clear, store to unmapped, plain unmapped read
    step(1'b0, A_SW, 32'hFFFF_FFFF, 1'b1);
    rd(A_SW, 2);
    step(1'b0, A_STAT, 32'h1, 1'b1);
    rd(A_STAT, 2);
    rd(32'h0000_0100, 2);
    step(1'b0, 32'h0000_0100, 32'h1234, 1'b1);
    rd(A_STAT, 2);
    step(1'b0, A_STAT, 32'h0, 1'b1);  // bit0 clear: err stays set
    rd(A_STAT, 1);
    step(1'b0, A_STAT, 32'h1, 1'b1);
    rd(A_RAM + 32'(4 * RAM_DEPTH), 2);

    // Read-during-write on word 0
    step(1'b0, A_RAM, 32'h11, 1'b1);
    step(1'b0, A_RAM, 32'h22, 1'b1);
    rd(A_RAM, 2);

    // Switch: 5-cycle glitch is ignored
    sw_in = 8'h01;
    rd(A_SW, 5);
    sw_in = 8'h00;
    rd(A_SW, 25);
    // Clean change is accepted after the debounce delay
    sw_in = 8'h3C;
    rd(A_SW, DEB_CYCLES + 6);
    // Reset in the middle of a debounce discards the candidate
    sw_in = 8'hF0;
    rd(A_SW, 8);
    step(1'b1, A_SW, 32'h0, 1'b0);
    rd(A_SW, DEB_CYCLES + 6);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        case ($urandom_range(0, 3))
          0: sw_in = 8'h00;
          1: sw_in = 8'h3C;
          2: sw_in = 8'hA5;
          default: sw_in = SW_W'($urandom());
        endcase
      end
      step(($urandom_range(0, 99) == 0), rand_addr(), $urandom(), ($urandom_range(0, 3) == 0));
    end

    step(1'b0, A_STAT, 32'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
